// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer: after a piece lands, scans the board bottom-to-top,
//   removes full rows, compacts the remaining rows downward and zero-fills the top.
// Latency: 2 cycles per row kept in place, 3 per row moved down, 1 per fill row, +1 done.
// Backpressure: none; start is accepted only in S_IDLE, ignored while busy (no queuing).
// Ports: piece_clk/RESET (sync, active-high); start in; busy/done/lines_cleared status out;
//   row_addr/row_rd_en/row_rd_data/row_wr_en/row_wr_data form the board RAM port (1-cycle read).
// Optional: define LINECLEAR_MASK_EN to add cleared_mask[ROWS-1:0] (original rows that were full).
module line_clear_sequencer #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int ROW_AW = 5,
    parameter int CNT_W  = 5
) (
    input  logic              piece_clk,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_cleared,
    output logic [ROW_AW-1:0] row_addr,
    output logic              row_rd_en,
    input  logic [COLS-1:0]   row_rd_data,
    output logic              row_wr_en,
    output logic [COLS-1:0]   row_wr_data
`ifdef LINECLEAR_MASK_EN
    ,
    output logic [ROWS-1:0]   cleared_mask
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_EVAL = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [ROW_AW-1:0] ROWS_A  = ROW_AW'(ROWS);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic [ROW_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [ROW_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  lines_q, lines_d;
    logic [COLS-1:0]   row_q, row_d;
    logic [ROW_AW-1:0] rd_inc, wr_inc;
    logic              row_full;

    assign rd_inc   = rd_ptr_q + 1'b1;
    assign wr_inc   = wr_ptr_q + 1'b1;
    assign row_full = &row_rd_data;

    // Once every original row has been read, either the board is already
    // compact (wr caught up) or the vacated top rows still need zeroing.
    function automatic logic [2:0] next_after_row(input logic [ROW_AW-1:0] rd,
                                                   input logic [ROW_AW-1:0] wr);
        if (rd != ROWS_A)
            return S_RD;
        else if (wr == ROWS_A)
            return S_DONE;
        else
            return S_FILL;
    endfunction

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        lines_d     = lines_q;
        row_d       = row_q;
        row_addr    = '0;
        row_rd_en   = 1'b0;
        row_wr_en   = 1'b0;
        row_wr_data = '0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    lines_d  = '0;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                row_rd_en = 1'b1;
                row_addr  = rd_ptr_q;
                state_d   = S_EVAL;
            end
            S_EVAL: begin
                if (row_full) begin
                    if (lines_q != CNT_MAX)
                        lines_d = lines_q + 1'b1;
                    rd_ptr_d = rd_inc;
                    state_d  = next_after_row(rd_inc, wr_ptr_q);
                end else if (rd_ptr_q == wr_ptr_q) begin
                    // Nothing removed below this row yet: it already sits in place.
                    rd_ptr_d = rd_inc;
                    wr_ptr_d = wr_inc;
                    state_d  = next_after_row(rd_inc, wr_inc);
                end else begin
                    row_d   = row_rd_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                row_wr_en   = 1'b1;
                row_addr    = wr_ptr_q;
                row_wr_data = row_q;
                rd_ptr_d    = rd_inc;
                wr_ptr_d    = wr_inc;
                state_d     = next_after_row(rd_inc, wr_inc);
            end
            S_FILL: begin
                row_wr_en = 1'b1;
                row_addr  = wr_ptr_q;
                wr_ptr_d  = wr_inc;
                if (wr_inc == ROWS_A)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge piece_clk) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            lines_q  <= '0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            lines_q  <= lines_d;
            row_q    <= row_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign lines_cleared = lines_q;

`ifdef LINECLEAR_MASK_EN
    logic [ROWS-1:0] mask_q, mask_d;

    // rd_ptr always names the original row index, so it marks the animation bit directly.
    always_comb begin
        mask_d = mask_q;
        if (state_q == S_IDLE && start)
            mask_d = '0;
        else if (state_q == S_EVAL && row_full)
            mask_d[rd_ptr_q] = 1'b1;
    end

    always_ff @(posedge piece_clk) begin
        if (RESET)
            mask_q <= '0;
        else
            mask_q <= mask_d;
    end

    assign cleared_mask = mask_q;
`endif

endmodule

// File: tb/tb_line_clear_sequencer.sv
// tb_line_clear_sequencer: table-driven passes over preset boards with a RAM model,
//   expected reads/writes/results queued at stimulus time and popped as the DUT acts.
// Hand sequences cover reset state, start held high, and reset in the middle of a move.
module tb_line_clear_sequencer;

    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int ROW_AW = 5;
    localparam int CNT_W  = 5;
    localparam int BW     = ROWS * COLS;

    logic              piece_clk = 1'b0;
    logic              RESET = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  lines_cleared;
    logic [ROW_AW-1:0] row_addr;
    logic              row_rd_en;
    logic [COLS-1:0]   row_rd_data = '0;
    logic              row_wr_en;
    logic [COLS-1:0]   row_wr_data;
`ifdef LINECLEAR_MASK_EN
    logic [ROWS-1:0]   cleared_mask;
`endif

    line_clear_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW), .CNT_W(CNT_W)
    ) dut (
        .piece_clk     (piece_clk),
        .RESET         (RESET),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .row_addr      (row_addr),
        .row_rd_en     (row_rd_en),
        .row_rd_data   (row_rd_data),
        .row_wr_en     (row_wr_en),
        .row_wr_data   (row_wr_data)
`ifdef LINECLEAR_MASK_EN
        ,
        .cleared_mask  (cleared_mask)
`endif
    );

    always #5 piece_clk = ~piece_clk;

    // Board RAM model with 1-cycle read latency and a bench-side preload.
    logic [COLS-1:0] mem [ROWS];
    logic            load_board = 1'b0;
    logic [BW-1:0]   init_board = '0;

    always @(posedge piece_clk) begin
        if (load_board) begin
            for (int r = 0; r < ROWS; r++)
                mem[r] <= init_board[r*COLS +: COLS];
        end else if (row_wr_en === 1'b1) begin
            mem[row_addr] <= row_wr_data;
        end
        if (row_rd_en === 1'b1)
            row_rd_data <= mem[row_addr];
    end

    typedef struct {
        string         name;
        logic [BW-1:0] board;
        int            exp_lines;
        int            exp_lat;
    } vec_t;

    typedef struct {
        int lines;
        int lat;
    } res_t;

    vec_t vecs [8];
    logic [ROW_AW-1:0]      rd_q [$];
    logic [ROW_AW+COLS-1:0] wr_q [$];
    res_t                   res_q [$];

    int errors = 0;
    int checks = 0;

    task automatic check_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_v(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any RAM access seen this cycle.
    task automatic tick();
        logic [ROW_AW+COLS-1:0] e;
        @(negedge piece_clk);
        if (row_rd_en === 1'b1 && row_wr_en === 1'b1)
            check_i("rd_wr_same_cycle", 1, 0);
        if (row_rd_en === 1'b1) begin
            if (rd_q.size() == 0) check_i("unexpected_read", int'(row_addr), -1);
            else check_i("rd_addr", int'(row_addr), int'(rd_q.pop_front()));
        end
        if (row_wr_en === 1'b1) begin
            if (wr_q.size() == 0) check_i("unexpected_write", int'(row_addr), -1);
            else begin
                e = wr_q.pop_front();
                check_i("wr_addr", int'(row_addr), int'(e[COLS +: ROW_AW]));
                check_i("wr_data", int'(row_wr_data), int'(e[0 +: COLS]));
            end
        end
    endtask

    // Reference compaction: kept rows slide down in order, vacated top rows become 0.
    task automatic model(input logic [BW-1:0] b, output logic [BW-1:0] fin, output int lines);
        int w;
        logic [COLS-1:0] row;
        fin = '0;
        w = 0;
        lines = 0;
        for (int r = 0; r < ROWS; r++) begin
            row = b[r*COLS +: COLS];
            if (row == '1) begin
                lines++;
            end else begin
                if (r != w) wr_q.push_back({ROW_AW'(w), row});
                fin[w*COLS +: COLS] = row;
                w++;
            end
        end
        for (int k = w; k < ROWS; k++)
            wr_q.push_back({ROW_AW'(k), COLS'(0)});
    endtask

    task automatic load(input logic [BW-1:0] b);
        init_board = b;
        load_board = 1'b1;
        tick();
        load_board = 1'b0;
        tick();
    endtask

    task automatic flush();
        rd_q.delete();
        wr_q.delete();
        res_q.delete();
    endtask

    task automatic run_pass(input vec_t v);
        logic [BW-1:0] fin;
        logic [BW-1:0] got;
        int   ml;
        int   cyc;
        int   busy_bad;
        res_t exp_r;
        load(v.board);
        model(v.board, fin, ml);
        for (int r = 0; r < ROWS; r++) rd_q.push_back(ROW_AW'(r));
        res_q.push_back('{lines: v.exp_lines, lat: v.exp_lat});
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 300) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
            cyc++;
        end
        if (done !== 1'b1) begin
            check_i({v.name, "_done_timeout"}, cyc, v.exp_lat);
        end else begin
            exp_r = res_q.pop_front();
            check_i({v.name, "_lines"}, int'(lines_cleared), exp_r.lines);
            check_i({v.name, "_latency"}, cyc, exp_r.lat);
            check_i({v.name, "_busy_at_done"}, int'(busy), 1);
        end
        check_i({v.name, "_busy_gaps"}, busy_bad, 0);
        tick();
        check_i({v.name, "_done_one_cycle"}, int'({done, busy}), 0);
        check_i({v.name, "_lines_hold"}, int'(lines_cleared), v.exp_lines);
        check_i({v.name, "_reads_left"}, rd_q.size(), 0);
        check_i({v.name, "_writes_left"}, wr_q.size(), 0);
        for (int r = 0; r < ROWS; r++) got[r*COLS +: COLS] = mem[r];
        check_v({v.name, "_board"}, got, fin);
        flush();
    endtask

    initial begin
        int d1, d2, extra, b42, b43, seen;

        for (int i = 0; i < 8; i++) vecs[i].board = '0;
        vecs[0].name = "empty";      vecs[0].exp_lines = 0;  vecs[0].exp_lat = 41;
        vecs[1].name = "one_clear";  vecs[1].exp_lines = 1;  vecs[1].exp_lat = 61;
        vecs[1].board[0*COLS +: COLS] = 10'h3FF;
        vecs[1].board[1*COLS +: COLS] = 10'h001;
        vecs[2].name = "four_clear"; vecs[2].exp_lines = 4;  vecs[2].exp_lat = 61;
        for (int r = 0; r < 4; r++) vecs[2].board[r*COLS +: COLS] = 10'h3FF;
        vecs[2].board[4*COLS +: COLS] = 10'h155;
        vecs[3].name = "top_full";   vecs[3].exp_lines = 1;  vecs[3].exp_lat = 42;
        vecs[3].board[19*COLS +: COLS] = 10'h3FF;
        vecs[4].name = "all_full";   vecs[4].exp_lines = 20; vecs[4].exp_lat = 61;
        for (int r = 0; r < ROWS; r++) vecs[4].board[r*COLS +: COLS] = 10'h3FF;
        vecs[5].name = "one_kept";   vecs[5].exp_lines = 19; vecs[5].exp_lat = 61;
        for (int r = 0; r < ROWS; r++) vecs[5].board[r*COLS +: COLS] = 10'h3FF;
        vecs[5].board[5*COLS +: COLS] = 10'h0F0;
        vecs[6].name = "none_full";  vecs[6].exp_lines = 0;  vecs[6].exp_lat = 41;
        for (int r = 0; r < ROWS; r++) vecs[6].board[r*COLS +: COLS] = 10'h155;
        vecs[7].name = "near_full";  vecs[7].exp_lines = 1;  vecs[7].exp_lat = 60;
        vecs[7].board[0*COLS +: COLS] = 10'h1FF;
        vecs[7].board[1*COLS +: COLS] = 10'h3FF;

        // Reset state
        RESET = 1'b1;
        repeat (3) tick();
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_done", int'(done), 0);
        check_i("rst_lines", int'(lines_cleared), 0);
        check_i("rst_rd_en", int'(row_rd_en), 0);
        check_i("rst_wr_en", int'(row_wr_en), 0);
        check_i("rst_addr", int'(row_addr), 0);
        check_i("rst_wr_data", int'(row_wr_data), 0);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_pass(vecs[i]);

        // start held high for 60 cycles: one pass, idle for one cycle, then a second pass.
        load('0);
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < ROWS; r++) rd_q.push_back(ROW_AW'(r));
        d1 = -1; d2 = -1; extra = 0; b42 = -1; b43 = -1;
        start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
                else extra++;
            end
            if (c == 42) b42 = int'(busy);
            if (c == 43) b43 = int'(busy);
            if (c == 60) start = 1'b0;
        end
        check_i("held_first_done", d1, 41);
        check_i("held_idle_gap_busy", b42, 0);
        check_i("held_restart_busy", b43, 1);
        check_i("held_second_done", d2, 83);
        check_i("held_extra_done", extra, 0);
        check_i("held_reads_left", rd_q.size(), 0);
        flush();

        // Reset in the S_WR of the first row move.
        load(vecs[1].board);
        begin
            logic [BW-1:0] fin_unused;
            int ml_unused;
            model(vecs[1].board, fin_unused, ml_unused);
        end
        for (int r = 0; r < ROWS; r++) rd_q.push_back(ROW_AW'(r));
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            if (row_wr_en === 1'b1) seen = 1;
            else tick();
        end
        check_i("midrst_saw_write", seen, 1);
        RESET = 1'b1;
        tick();
        check_i("midrst_busy", int'(busy), 0);
        check_i("midrst_wr_en", int'(row_wr_en), 0);
        check_i("midrst_rd_en", int'(row_rd_en), 0);
        check_i("midrst_lines", int'(lines_cleared), 0);
        check_i("midrst_done", int'(done), 0);
        RESET = 1'b0;
        flush();
        tick();
        check_i("midrst_stays_idle", int'(busy), 0);
        run_pass(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
